// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS32 multi-cycle control path: state codes, opcodes,
// ALU operation classes and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_EXEC_R  = 4'd6;
    localparam logic [3:0] ST_RWB     = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_JUMP    = 4'd9;
    localparam logic [3:0] ST_ADDI_EX = 4'd10;
    localparam logic [3:0] ST_ORI_EX  = 4'd11;
    localparam logic [3:0] ST_IMMWB   = 4'd12;
    localparam logic [3:0] ST_TRAP    = 4'd13;

    typedef enum logic [3:0] {
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_MEMADR  = ST_MEMADR,
        S_MEMRD   = ST_MEMRD,
        S_MEMWB   = ST_MEMWB,
        S_MEMWR   = ST_MEMWR,
        S_EXEC_R  = ST_EXEC_R,
        S_RWB     = ST_RWB,
        S_BRANCH  = ST_BRANCH,
        S_JUMP    = ST_JUMP,
        S_ADDI_EX = ST_ADDI_EX,
        S_ORI_EX  = ST_ORI_EX,
        S_IMMWB   = ST_IMMWB,
        S_TRAP    = ST_TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state-to-control decoder; only FETCH looks at mem_ready so the
// instruction register and PC update in the cycle the fetch completes.
module mips_mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ORI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_zext  = 1'b1;
                ctrl.alu_op    = ALU_OR;
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
            end
            // beq compares A-B; the target was computed into ALUOut during DECODE
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS32 main control: state register, next-state logic, opcode latch
// and sticky illegal-opcode flag; output decoding lives in mips_mc_outdec.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter bit IGNORE_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ORI:       state_d = S_ORI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = IGNORE_ILLEGAL ? S_FETCH : S_TRAP;
                endcase
            end
            // only lw and sw can reach MEMADR, so the latched opcode picks the access
            S_MEMADR: begin
                if (opcode_q == OP_LW)      state_d = S_MEMRD;
                else if (opcode_q == OP_SW) state_d = S_MEMWR;
                else                        state_d = S_FETCH;
            end
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_MEMWB:   state_d = S_FETCH;
            S_EXEC_R:  state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_ADDI_EX: state_d = S_IMMWB;
            S_ORI_EX:  state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
        if (state_d == S_TRAP) illegal_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    mips_mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Reset masks every output so no write enable can fire in the reset cycle
    always_comb begin
        pc_write_en = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        imm_zext    = 1'b0;
        alu_op      = 2'b00;
        pc_source   = 2'b00;
        illegal_op  = 1'b0;
        state       = ST_FETCH;
        if (!rst) begin
            pc_write_en = ctrl.pc_write | (ctrl.pc_write_cond & zero);
            i_or_d      = ctrl.i_or_d;
            mem_read    = ctrl.mem_read;
            mem_write   = ctrl.mem_write;
            ir_write    = ctrl.ir_write;
            reg_write   = ctrl.reg_write;
            reg_dst     = ctrl.reg_dst;
            mem_to_reg  = ctrl.mem_to_reg;
            alu_src_a   = ctrl.alu_src_a;
            alu_src_b   = ctrl.alu_src_b;
            imm_zext    = ctrl.imm_zext;
            alu_op      = ctrl.alu_op;
            pc_source   = ctrl.pc_source;
            illegal_op  = illegal_q;
            state       = state_q;
        end
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle main control unit for the MIPS32 core. It sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath enable and mux select. It also produces the 2-bit ALU operation class consumed directly downstream by the ALU control decoder (00 add, 01 subtract, 10 decode funct, 11 or). Memory accesses stall on a ready handshake.

## Interface
- `IGNORE_ILLEGAL`, default 0: 0 sends an unknown opcode to TRAP; 1 treats it as a NOP and returns to FETCH.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; sampled in DECODE only.
- `zero`  in  1  ALU zero flag; used in BRANCH only.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_write_en`  out  1  PC load = pc_write | (pc_write_cond & zero), formed internally.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  IR load.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  register-file controls.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = immediate, 11 = immediate<<2.
- `imm_zext`  out  1  immediate zero-extended when 1, sign-extended when 0.
- `alu_op`  out  2  ALU operation class for the ALU control decoder.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  sticky flag, set on entry to TRAP.
- `state`  out  4  current state code, for debug.

## Operation
- Moore FSM with one registered state. All outputs are decoded from state, except the `mem_ready` gating noted below. Unlisted outputs are 0.
- FETCH:
  - Drives mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write_en equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE: drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
  - 0x00 goes to EXEC_R.
  - 0x23 or 0x2B goes to MEMADR.
  - 0x04 goes to BRANCH.
  - 0x08 goes to ADDI_EX.
  - 0x0D goes to ORI_EX.
  - 0x02 goes to JUMP.
  - Any other opcode goes to TRAP, or to FETCH when IGNORE_ILLEGAL=1.
- MEMADR: drives alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for 0x23, MEMWR for 0x2B. The opcode is latched in DECODE.
- MEMRD: drives i_or_d=1, mem_read=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: drives reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: drives i_or_d=1, mem_write=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R: drives alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RWB.
- RWB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- ADDI_EX: drives alu_src_a=1, alu_src_b=10, alu_op=00. Goes to IMMWB.
- ORI_EX: drives alu_src_a=1, alu_src_b=10, imm_zext=1, alu_op=11. Goes to IMMWB.
- IMMWB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - Asserts pc_write_cond, so pc_write_en equals zero.
  - Goes to FETCH.
- JUMP: pc_source=10, pc_write_en=1. Goes to FETCH.
- TRAP: all enables are 0; stays in TRAP until rst.

## Timing
- Reset:
  - While rst=1, every output is forced to 0, `state` reads the FETCH code, and illegal_op is cleared.
  - The first fetch strobe appears in the cycle after rst falls.
- Latency with mem_ready held at 1: beq and j take 3 cycles; R-type, sw, addi and ori take 4; lw takes 5.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs hold steady during the wait.
- mem_ready is ignored in every other state.
- rst asserted in any state, including mid-wait, returns the FSM to FETCH on the next edge. No write enable fires in the reset cycle.
- `opcode` is latched on the DECODE edge. Later changes to `opcode` do not alter the sequence.

## Structure
- Package `mips_ctrl_pkg`:
  - State encoding as 4-bit localparams.
  - Opcode constants.
  - ALU-op class codes (ADD=00, SUB=01, FUNCT=10, OR=11).
  - alu_src_b and pc_source codes.
  - Shared with the ALU control decoder and the datapath.
- One sub-module, `mips_mc_outdec`: a purely combinational state-to-output decoder. The top module holds the state register, the next-state logic, the opcode latch and illegal_op.

## Test plan
- rst for 2 cycles, then release with mem_ready=1 → all outputs 0 during reset; cycle 1 after release shows mem_read=1, ir_write=1, pc_write_en=1, alu_src_b=01.
- opcode=0x23, mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_to_reg=1 in cycle 5.
- opcode=0x2B, mem_ready held low for 3 cycles in MEMWR → mem_write stays asserted for 4 cycles, then FETCH.
- opcode=0x04 with zero=1, then zero=0 → pc_write_en=1, then pc_write_en=0, in BRANCH; alu_op=01 in both cases.
- opcode=0x0D → alu_op=11 and imm_zext=1 in ORI_EX; reg_write=1 with reg_dst=0 in IMMWB; total 4 cycles.
- opcode=0x3F with IGNORE_ILLEGAL=0 → TRAP, illegal_op=1, held until rst; with IGNORE_ILLEGAL=1 → back to FETCH after DECODE and illegal_op stays 0.
